// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity codes,
// FSM state encoding and the frame-length helper.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    function automatic int frame_cycles(input int clk_div, input int data_bits,
                                        input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clk_div;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is visible on dout
// whenever the FIFO is not empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Same index with differing wrap bit means the writer has lapped the reader.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (we && !full)
                wptr <= wptr + 1'b1;
            if (re && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !full)
            mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-fed, clock-enable baud timing, configurable data
// bits, parity and stop bits. tx and busy are registered.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 we,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    input  logic                 ovf_clr,
    output logic                 tx
);
    localparam int CW = $clog2(CLK_DIV);

    tx_state_t            state;
    logic [CW-1:0]        baud;
    logic [2:0]           bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] head;
    logic                 par_bit;
    logic                 tick;
    logic                 last_stop;
    logic                 pop;

    function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign tick      = (baud == CW'(CLK_DIV - 1));
    assign last_stop = (bitcnt == 3'(STOP_BITS - 1));
    // Pop from IDLE, or straight out of the final stop bit for gapless frames.
    assign pop = !empty && ((state == S_IDLE) ||
                            (state == S_STOP && tick && last_stop));

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .din   (data),
        .re    (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            baud <= (state == S_IDLE || tick) ? '0 : baud + 1'b1;
            if (pop) begin
                state   <= S_START;
                shreg   <= head;
                par_bit <= calc_par(head);
                bitcnt  <= '0;
                tx      <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    S_START: if (tick) begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    S_DATA: if (tick) begin
                        if (bitcnt == 3'(DATA_BITS - 1)) begin
                            bitcnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
                    end
                    S_PARITY: if (tick) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                    S_STOP: if (tick) begin
                        if (last_stop) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A dropped write outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (we && full)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed and soak bench for uart_tx_param over five parameter sets.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int N = 5;
    localparam int CD [N] = '{4, 4, 3, 4, 2};
    localparam int DB [N] = '{8, 8, 7, 8, 5};
    localparam int PR [N] = '{2, 1, 0, 0, 1};
    localparam int SB [N] = '{1, 1, 2, 1, 2};
    localparam int DP [N] = '{16, 16, 8, 4, 2};

    logic             clk = 1'b0;
    logic [N-1:0]     rst_v = '1;
    logic [N-1:0]     we_v = '0;
    logic [N-1:0]     ovf_clr_v = '0;
    logic [N-1:0][7:0] data_v = '0;
    logic [N-1:0]     full_v, empty_v, busy_v, overflow_v, tx_v;

    int asserts = 0;
    int fails = 0;
    logic [7:0] sent [N][32];

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_DIV(CD[0]), .DATA_BITS(DB[0]), .PARITY(PR[0]), .STOP_BITS(SB[0]), .FIFO_DEPTH(DP[0])) u0 (
        .clk(clk), .rst(rst_v[0]), .data(data_v[0][7:0]), .we(we_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .busy(busy_v[0]), .overflow(overflow_v[0]), .ovf_clr(ovf_clr_v[0]), .tx(tx_v[0]));
    uart_tx_param #(.CLK_DIV(CD[1]), .DATA_BITS(DB[1]), .PARITY(PR[1]), .STOP_BITS(SB[1]), .FIFO_DEPTH(DP[1])) u1 (
        .clk(clk), .rst(rst_v[1]), .data(data_v[1][7:0]), .we(we_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .busy(busy_v[1]), .overflow(overflow_v[1]), .ovf_clr(ovf_clr_v[1]), .tx(tx_v[1]));
    uart_tx_param #(.CLK_DIV(CD[2]), .DATA_BITS(DB[2]), .PARITY(PR[2]), .STOP_BITS(SB[2]), .FIFO_DEPTH(DP[2])) u2 (
        .clk(clk), .rst(rst_v[2]), .data(data_v[2][6:0]), .we(we_v[2]), .full(full_v[2]), .empty(empty_v[2]),
        .busy(busy_v[2]), .overflow(overflow_v[2]), .ovf_clr(ovf_clr_v[2]), .tx(tx_v[2]));
    uart_tx_param #(.CLK_DIV(CD[3]), .DATA_BITS(DB[3]), .PARITY(PR[3]), .STOP_BITS(SB[3]), .FIFO_DEPTH(DP[3])) u3 (
        .clk(clk), .rst(rst_v[3]), .data(data_v[3][7:0]), .we(we_v[3]), .full(full_v[3]), .empty(empty_v[3]),
        .busy(busy_v[3]), .overflow(overflow_v[3]), .ovf_clr(ovf_clr_v[3]), .tx(tx_v[3]));
    uart_tx_param #(.CLK_DIV(CD[4]), .DATA_BITS(DB[4]), .PARITY(PR[4]), .STOP_BITS(SB[4]), .FIFO_DEPTH(DP[4])) u4 (
        .clk(clk), .rst(rst_v[4]), .data(data_v[4][4:0]), .we(we_v[4]), .full(full_v[4]), .empty(empty_v[4]),
        .busy(busy_v[4]), .overflow(overflow_v[4]), .ovf_clr(ovf_clr_v[4]), .tx(tx_v[4]));

    function automatic int flen(input int k);
        return frame_cycles(CD[k], DB[k], PR[k], SB[k]);
    endfunction

    // Returns at the negedge after the write edge; the pop edge is next.
    task automatic write_one(input int k, input logic [7:0] d);
        @(negedge clk);
        we_v[k] = 1'b1;
        data_v[k] = d;
        @(posedge clk);
        @(negedge clk);
        we_v[k] = 1'b0;
    endtask

    // Cycle-exact frame check starting at the pop edge; exp bit i is frame bit i.
    task automatic check_frame(input int k, input logic [11:0] exp, input string name);
        int len;
        len = flen(k);
        @(posedge clk);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            asserts++;
            if (tx_v[k] !== exp[c / CD[k]]) begin
                fails++;
                $display("FAIL %s k=%0d cycle %0d: tx=%b expected %b", name, k, c, tx_v[k], exp[c / CD[k]]);
            end
            if (c == 0 || c == len - 1) begin
                asserts++;
                if (busy_v[k] !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_busy k=%0d cycle %0d: busy=%b expected 1", name, k, c, busy_v[k]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        asserts++;
        if (busy_v[k] !== 1'b0 || tx_v[k] !== 1'b1) begin
            fails++;
            $display("FAIL %s_end k=%0d: busy=%b tx=%b expected busy=0 tx=1", name, k, busy_v[k], tx_v[k]);
        end
    endtask

    task automatic test_reset;
        rst_v = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            asserts++;
            if ({tx_v[k], busy_v[k], full_v[k], empty_v[k], overflow_v[k]} !== 5'b10010) begin
                fails++;
                $display("FAIL reset k=%0d: tx,busy,full,empty,ovf=%b expected 10010", k,
                         {tx_v[k], busy_v[k], full_v[k], empty_v[k], overflow_v[k]});
            end
        end
        rst_v = '0;
    endtask

    task automatic test_even;
        write_one(0, 8'hA5);
        asserts++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || empty_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL even_nobypass: tx=%b busy=%b empty=%b expected 1 0 0", tx_v[0], busy_v[0], empty_v[0]);
        end
        check_frame(0, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, "even_a5");
    endtask

    task automatic test_odd;
        write_one(1, 8'h00);
        check_frame(1, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, "odd_00");
    endtask

    task automatic test_seven_two_stop;
        write_one(2, 8'h7F);
        check_frame(2, {2'b00, 2'b11, 7'h7F, 1'b0}, "7n2_7f");
    endtask

    task automatic test_overflow;
        logic [7:0] bytes [6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    we_v[3] = 1'b1;
                    data_v[3] = bytes[i];
                    @(posedge clk);
                    @(negedge clk);
                    if (i >= 3) begin
                        asserts++;
                        if (full_v[3] !== (i >= 4) || overflow_v[3] !== (i == 5)) begin
                            fails++;
                            $display("FAIL ovf_edge%0d: full=%b ovf=%b expected full=%b ovf=%b", i,
                                     full_v[3], overflow_v[3], i >= 4, i == 5);
                        end
                    end
                end
                we_v[3] = 1'b0;
            end
            begin
                logic e;
                int b;
                @(posedge clk);
                @(posedge clk);
                for (int c = 0; c < 5 * 40; c++) begin
                    @(negedge clk);
                    b = (c % 40) / 4;
                    e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bytes[c / 40][b - 1];
                    asserts++;
                    if (tx_v[3] !== e || busy_v[3] !== 1'b1) begin
                        fails++;
                        $display("FAIL ovf_stream cycle %0d: tx=%b busy=%b expected tx=%b busy=1", c, tx_v[3], busy_v[3], e);
                    end
                end
                @(posedge clk);
                @(negedge clk);
                asserts++;
                if (busy_v[3] !== 1'b0 || empty_v[3] !== 1'b1 || overflow_v[3] !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_drain: busy=%b empty=%b ovf=%b expected 0 1 1", busy_v[3], empty_v[3], overflow_v[3]);
                end
            end
        join
        ovf_clr_v[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovf_clr_v[3] = 1'b0;
        asserts++;
        if (overflow_v[3] !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow_v[3]);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        we_v[0] = 1'b1;
        data_v[0] = 8'h55;
        @(posedge clk);
        @(negedge clk);
        data_v[0] = 8'h99;
        @(posedge clk);
        @(negedge clk);
        we_v[0] = 1'b0;
        repeat (13) @(negedge clk);
        asserts++;
        if (busy_v[0] !== 1'b1 || empty_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL midframe_pre: busy=%b empty=%b expected 1 0", busy_v[0], empty_v[0]);
        end
        rst_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_v[0] = 1'b0;
        asserts++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || empty_v[0] !== 1'b1) begin
            fails++;
            $display("FAIL midframe_rst: tx=%b busy=%b empty=%b expected 1 0 1", tx_v[0], busy_v[0], empty_v[0]);
        end
        write_one(0, 8'h3C);
        check_frame(0, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, "after_rst_3c");
    endtask

    // Mid-bit sampling receiver; good=0 on timeout, framing or parity error.
    task automatic rx_frame(input int k, output logic [7:0] d, output logic good);
        int t;
        int bud;
        good = 1'b1;
        d = '0;
        t = 0;
        bud = 20 * flen(k);
        @(negedge clk);
        while (tx_v[k] !== 1'b0 && t < bud) begin
            @(negedge clk);
            t++;
        end
        if (t >= bud) begin
            good = 1'b0;
        end else begin
            repeat (CD[k] / 2) @(negedge clk);
            if (tx_v[k] !== 1'b0) good = 1'b0;
            for (int b = 0; b < DB[k]; b++) begin
                repeat (CD[k]) @(negedge clk);
                d[b] = tx_v[k];
            end
            if (PR[k] != PAR_NONE) begin
                repeat (CD[k]) @(negedge clk);
                if (tx_v[k] !== ((PR[k] == PAR_ODD) ? ~^d : ^d)) good = 1'b0;
            end
            for (int s = 0; s < SB[k]; s++) begin
                repeat (CD[k]) @(negedge clk);
                if (tx_v[k] !== 1'b1) good = 1'b0;
            end
        end
    endtask

    task automatic soak(input int k, input int n);
        fork
            begin
                int t;
                logic [7:0] d;
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3 * flen(k))) @(negedge clk);
                    t = 0;
                    while (full_v[k] && t < 2000) begin
                        @(negedge clk);
                        t++;
                    end
                    d = 8'($urandom) & 8'((1 << DB[k]) - 1);
                    sent[k][i] = d;
                    we_v[k] = 1'b1;
                    data_v[k] = d;
                    @(posedge clk);
                    @(negedge clk);
                    we_v[k] = 1'b0;
                end
            end
            begin
                logic [7:0] d;
                logic good;
                for (int i = 0; i < n; i++) begin
                    rx_frame(k, d, good);
                    asserts++;
                    if (!good || d !== sent[k][i]) begin
                        fails++;
                        $display("FAIL soak k=%0d byte %0d: got %h good=%b expected %h", k, i, d, good, sent[k][i]);
                    end
                end
            end
        join
        asserts++;
        if (overflow_v[k] !== 1'b0 || empty_v[k] !== 1'b1) begin
            fails++;
            $display("FAIL soak_end k=%0d: ovf=%b empty=%b expected 0 1", k, overflow_v[k], empty_v[k]);
        end
    endtask

    task automatic test_soak;
        fork
            soak(0, 12);
            soak(1, 12);
            soak(2, 12);
            soak(4, 16);
        join
    endtask

    initial begin
        test_reset;
        test_even;
        test_odd;
        test_seven_two_stop;
        test_overflow;
        test_reset_midframe;
        test_soak;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an internal transmit FIFO, a clock-enable baud generator, and configurable frame format: data bits, parity and stop bits. It replaces the fixed 8N1, derived-clock transmitter in the display-measurement cores and sits between the measurement logic and the board's USB-UART TX pin. All logic runs on the single system clock, with no generated clocks.

## Interface
Parameters:
- CLK_DIV, 16: system clocks per bit period; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal values 5 to 8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk in 1: system clock; all logic on the rising edge.
- rst in 1: reset, synchronous, active-high.
- data in DATA_BITS: byte to transmit; sampled when we=1 and full=0.
- we in 1: write strobe, one entry per cycle.
- full out 1: FIFO holds FIFO_DEPTH entries.
- empty out 1: FIFO holds 0 entries.
- busy out 1: a frame is in progress; low only in IDLE.
- overflow out 1: sticky; set when we=1 while full=1.
- ovf_clr in 1: clears overflow.
- tx out 1: serial line; idles high; registered output.

## Operation
- Reset: tx=1, busy=0, full=0, empty=1, overflow=0. The FIFO is flushed, the FSM goes to IDLE, and the baud counter is cleared. Reset asserted mid-frame aborts the frame, and tx is 1 after that edge.
- FIFO write: on we=1 and full=0, data is stored. A write with full=1 is dropped, even if a pop happens in the same cycle, and it sets overflow. If ovf_clr and a dropped write occur in the same cycle, the set wins.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If empty=0, pop the head entry into the shift register, clear the bit counter and baud counter, and go to START.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: shift out LSB first, DATA_BITS bit periods. Then go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY: one bit period. Odd parity sends the XOR of the data bits inverted; even parity sends that XOR unchanged.
  - STOP: tx=1 for STOP_BITS bit periods. Then, if empty=0, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1, width $clog2(CLK_DIV). Its terminal count advances the FSM. It restarts at every frame load, so frame timing is aligned to the pop, not free-running.
- Simultaneous write and pop: both occur and the count is unchanged. A write into an empty FIFO is not bypassed; it is popped no earlier than the next edge.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits wide. full and empty are derived from the extra MSB, so there are no off-by-one states at wrap.

## Timing
- Byte written at edge N into an idle, empty block: the pop happens at edge N+1, and tx first reads 0 after edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles. Every bit lasts exactly CLK_DIV cycles.
- busy rises with the first start bit. It falls at the end of the last stop bit only when the FIFO is empty.
- full, empty and overflow update on the edge following the causing event.

## Structure
- Shared package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the FSM state enum;
  - a frame-length function used by the bench.
- Sub-module uart_tx_fifo is a synchronous single-clock FIFO with parameters WIDTH and DEPTH, and ports we/din/re/dout/full/empty.
- The top level contains the baud counter, the FSM, the shift register, the parity accumulator and the overflow flag.

## Test plan
- Even parity: CLK_DIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; write 0xA5.
  - Required tx sequence, 4 cycles per bit: 0 | 1 0 1 0 0 1 0 1 | 0 | 1.
  - 44 cycles total; busy is low again at cycle 45.
- Odd parity: PARITY=1, write 0x00 → parity bit is 1.
- Seven bits, two stops: DATA_BITS=7, PARITY=0, STOP_BITS=2; write 0x7F.
  - Required frame: start 0, seven 1s, two stop bits.
  - 10 bit periods, with tx high for the final two.
- Overflow: FIFO_DEPTH=4, six writes on consecutive edges 0..5.
  - Edges 0–4 accepted (pop at edge 1); full is high after edge 4.
  - Write at edge 5 dropped; overflow=1 after edge 5.
  - Five frames are transmitted back-to-back with no idle gap.
  - A subsequent ovf_clr pulse clears overflow.
- Reset mid-frame: assert rst during bit 3 of a 0x55 frame.
  - Required: tx=1, busy=0, empty=1 after that edge.
  - A fresh write of 0x3C then transmits correctly.
- Random soak: random data, randomised write gaps, all legal parameter combinations.
  - A UART receiver model must recover every accepted byte in order with correct parity.
  - No dropped byte unless overflow was set.
